pixel_frame_loader: RTL and testbench

- Upstream feeder for the MLP accelerator core.
- Accepts a byte-serial pixel stream over a valid/ready handshake and assembles one IN_DIM-pixel frame into a flat parallel bus.
- Issues a one-cycle start pulse to the hidden layer, then holds the bus stable until the core reports output_finished.
- Detects malformed frames: short frames, and long frames with a missing or late last flag.

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/pixel_frame_loader_if.sv | 38 +++
 rtl/pixel_clamp.sv | 25 ++
 rtl/pixel_frame_loader.sv | 125 ++++++++++++
 tb/tb_pixel_frame_loader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// ============================================================================
// Module   : mlp_pkg
// Purpose  : Shared types and defaults for the MLP accelerator front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_pkg;

  localparam int DEF_IN_DIM  = 64;
  localparam int DEF_DATA_W  = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    FIRE  = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_frame_loader_if.sv
// ============================================================================
// Module   : pixel_frame_loader_if
// Purpose  : Pixel stream, frame bus and core handshake bundle for the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_frame_loader_if
  import mlp_pkg::*;
#(
  parameter int IN_DIM = DEF_IN_DIM,
  parameter int DATA_W = DEF_DATA_W
);

  logic                      s_valid;
  logic [DATA_W-1:0]         s_data;
  logic                      s_last;
  logic                      s_ready;
  logic [DATA_W*IN_DIM-1:0]  bus_out;
  logic                      start;
  logic                      core_done;
  logic                      busy;
  logic                      frame_err;
  logic [FRAME_CNT_W-1:0]    frame_cnt;

  modport master (
    output s_valid, s_data, s_last, core_done,
    input  s_ready, bus_out, start, busy, frame_err, frame_cnt
  );

  modport slave (
    input  s_valid, s_data, s_last, core_done,
    output s_ready, bus_out, start, busy, frame_err, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pixel_clamp.sv
// ============================================================================
// Module   : pixel_clamp
// Purpose  : Combinational unsigned saturator, out = min(din, MAX_VAL).
//            Only built when LOADER_CLAMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef LOADER_CLAMP_EN
module pixel_clamp #(
  parameter int DATA_W  = 8,
  parameter int MAX_VAL = 16
) (
  input  wire logic [DATA_W-1:0] din,
  output logic      [DATA_W-1:0] dout
);

  localparam logic [DATA_W-1:0] C_CEIL = DATA_W'(MAX_VAL);

  assign dout = (din > C_CEIL) ? C_CEIL : din;

endmodule
`endif

`default_nettype wire

// File: rtl/pixel_frame_loader.sv
// ============================================================================
// Module   : pixel_frame_loader
// Purpose  : Assembles a byte-serial pixel stream into one IN_DIM-pixel frame,
//            pulses start to the core and holds the frame until core_done.
//            Optional macro LOADER_CLAMP_EN saturates each pixel at MAX_PIX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_frame_loader
  import mlp_pkg::*;
#(
  parameter int IN_DIM = DEF_IN_DIM,
  parameter int DATA_W = DEF_DATA_W
`ifdef LOADER_CLAMP_EN
  ,
  parameter int MAX_PIX = 16
`endif
) (
  input wire logic            clk,
  input wire logic            rst,
  pixel_frame_loader_if.slave pix
);

  localparam int                IDX_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_DIM - 1);

  loader_state_t              r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [DATA_W*IN_DIM-1:0]   r_bus;
  logic                       r_start;
  logic                       r_frame_err;
  logic                       r_busy;
  logic [FRAME_CNT_W-1:0]     r_frame_cnt;

  logic                       w_ready;
  logic                       w_beat;
  logic                       w_last_slot;
  logic [DATA_W-1:0]          w_pix;

`ifdef LOADER_CLAMP_EN
  pixel_clamp #(
    .DATA_W  (DATA_W),
    .MAX_VAL (MAX_PIX)
  ) u_pixel_clamp (
    .din  (pix.s_data),
    .dout (w_pix)
  );
`else
  assign w_pix = pix.s_data;
`endif

  assign w_ready     = (r_state == LOAD) || (r_state == DRAIN);
  assign w_beat      = pix.s_valid && w_ready;
  assign w_last_slot = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_bus       <= '0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_beat) begin
            r_bus[int'(r_idx)*DATA_W +: DATA_W] <= w_pix;
            // Slot check precedes the increment, so idx never wraps.
            if (w_last_slot) begin
              r_idx <= '0;
              if (pix.s_last) begin
                r_state <= FIRE;
                r_start <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_state     <= DRAIN;
                r_frame_err <= 1'b1;
              end
            end else if (pix.s_last) begin
              r_idx       <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          // Overlong frame: the first IN_DIM bytes are kept, the tail is dropped.
          if (w_beat && pix.s_last) begin
            r_state <= FIRE;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        FIRE: begin
          r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
          r_state     <= WAIT;
        end
        WAIT: begin
          if (pix.core_done) begin
            r_state <= LOAD;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign pix.s_ready   = w_ready;
  assign pix.bus_out   = r_bus;
  assign pix.start     = r_start;
  assign pix.busy      = r_busy;
  assign pix.frame_err = r_frame_err;
  assign pix.frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
// ============================================================================
// Module   : tb_pixel_frame_loader
// Purpose  : Scoreboard bench for pixel_frame_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_frame_loader;

  localparam int IN_DIM = 64;
  localparam int DATA_W = 8;
  localparam int BUS_W  = IN_DIM * DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;
  int   next_wait = 0;
  bit   mon_busy = 1'b0;

  typedef struct {
    bit               is_start;
    int               cyc;
    logic [BUS_W-1:0] bus;
    int               cnt;
    int               dly;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_frame_loader_if #(.IN_DIM(IN_DIM), .DATA_W(DATA_W)) ifc ();

  pixel_frame_loader #(.IN_DIM(IN_DIM), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .pix (ifc.slave)
  );

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef LOADER_CLAMP_EN
    return (v > 8'd16) ? 8'd16 : v;
`else
    return v;
`endif
  endfunction

  // Present one beat and wait (bounded) until it will be taken at the next edge.
  task automatic present(input logic [7:0] d, input logic l, output int edge_no);
    int guard;
    if ($urandom_range(0, 3) == 0) begin
      ifc.s_valid = 1'b0;
      ifc.s_data  = 8'($urandom);
      @(negedge clk);
    end
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = l;
    guard = 0;
    while (ifc.s_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: s_ready=%0b, expected 1", ifc.s_ready);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "s_ready never returned");
      end
    end
    edge_no = cyc;
  endtask

  task automatic push_ev(input bit is_start, input int c, input logic [BUS_W-1:0] b, input int n);
    ev_t ev;
    ev.is_start = is_start;
    ev.cyc      = c;
    ev.bus      = b;
    ev.cnt      = n;
    ev.dly      = next_wait;
    sb.push_back(ev);
  endtask

  // Frame model: last beat index decides short / exact / overlong outcome.
  task automatic send_frame(input logic [7:0] d[$], input int last_at);
    logic [BUS_W-1:0] b;
    int e;
    b = '0;
    if (last_at >= IN_DIM - 1)
      for (int k = 0; k < IN_DIM; k++) b[k*DATA_W +: DATA_W] = stored(d[k]);
    for (int i = 0; i <= last_at; i++) begin
      present(d[i], (i == last_at), e);
      if (i == last_at && last_at < IN_DIM - 1) push_ev(1'b0, e + 1, '0, 0);
      if (i == IN_DIM - 1 && last_at > IN_DIM - 1) push_ev(1'b0, e + 1, '0, 0);
      if (i == last_at && last_at >= IN_DIM - 1) begin
        exp_cnt++;
        push_ev(1'b1, e + 1, b, exp_cnt);
      end
      @(negedge clk);
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  initial begin : monitor
    bit               prev_start;
    bit               in_wait;
    bit               stable;
    int               countdown;
    int               held_cnt;
    logic [BUS_W-1:0] hold;
    ev_t              ev;
    prev_start = 1'b0;
    in_wait    = 1'b0;
    stable     = 1'b0;
    countdown  = 0;
    held_cnt   = 0;
    hold       = '0;
    ifc.core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.core_done) begin
        ifc.core_done = 1'b0;
        chk("ready_after_done", ifc.s_ready, 1);
        chk("busy_after_done", ifc.busy, 0);
      end
      if (ifc.frame_err === 1'b1) begin
        chk("err_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          chk("err_kind", ev.is_start, 0);
          chk("err_cycle", cyc, ev.cyc);
        end
      end
      if (ifc.start === 1'b1) begin
        chk("start_gap", prev_start, 0);
        chk("start_expected", sb.size() != 0, 1);
        countdown = 0;
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          chk("start_kind", ev.is_start, 1);
          chk("start_cycle", cyc, ev.cyc);
          chk("bus_out", ifc.bus_out, ev.bus);
          held_cnt  = ev.cnt;
          countdown = ev.dly;
        end
        chk("busy_in_fire", ifc.busy, 1);
        in_wait = 1'b1;
        hold    = ifc.bus_out;
        stable  = 1'b1;
      end else if (in_wait) begin
        if (ifc.bus_out !== hold || ifc.s_ready !== 1'b0 || ifc.busy !== 1'b1) stable = 1'b0;
        if (countdown == 0) begin
          chk("wait_hold", stable, 1);
          chk("frame_cnt", ifc.frame_cnt, held_cnt);
          ifc.core_done = 1'b1;
          in_wait = 1'b0;
        end else begin
          countdown--;
        end
      end
      prev_start = ifc.start;
      mon_busy   = in_wait || ifc.core_done;
    end
  end

  initial begin : driver
    logic [7:0] d[$];
    int e;
    int g;
    int kind;
    int last_at;
    rst = 1'b1;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_ready", ifc.s_ready, 1);
    chk("rst_start", ifc.start, 0);
    chk("rst_frame_err", ifc.frame_err, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_frame_cnt", ifc.frame_cnt, 0);
    chk("rst_bus_out", ifc.bus_out, 0);

    // Ramp frame 0..63
    d.delete();
    for (int i = 0; i < IN_DIM; i++) d.push_back(8'(i));
    next_wait = 3;
    send_frame(d, IN_DIM - 1);

    // Short frame, then a full 0xAA frame
    d.delete();
    for (int i = 0; i < 11; i++) d.push_back(8'($urandom));
    send_frame(d, 10);
    d.delete();
    for (int i = 0; i < IN_DIM; i++) d.push_back(8'hAA);
    send_frame(d, IN_DIM - 1);

    // Overlong frame with last on beat 69
    d.delete();
    for (int i = 0; i < 70; i++) d.push_back(8'($urandom));
    send_frame(d, 69);

    // Long hold with input noise while the core is busy
    d.delete();
    for (int i = 0; i < IN_DIM; i++) d.push_back(8'($urandom));
    next_wait = 210;
    send_frame(d, IN_DIM - 1);
    for (int i = 0; i < 200; i++) begin
      ifc.s_valid = 1'($urandom);
      ifc.s_data  = 8'($urandom);
      ifc.s_last  = 1'($urandom);
      @(negedge clk);
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    next_wait = 2;

    // Reset in the middle of a frame
    d.delete();
    for (int i = 0; i < 30; i++) d.push_back(8'($urandom));
    for (int i = 0; i < 30; i++) begin
      present(d[i], 1'b0, e);
      @(negedge clk);
    end
    ifc.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("midrst_frame_cnt", ifc.frame_cnt, 0);
    chk("midrst_s_ready", ifc.s_ready, 1);
    chk("midrst_busy", ifc.busy, 0);
    d.delete();
    for (int i = 0; i < IN_DIM; i++) d.push_back(8'($urandom));
    send_frame(d, IN_DIM - 1);

    // Clamp boundary values in the first slots
    d.delete();
    d.push_back(8'd0);
    d.push_back(8'd16);
    d.push_back(8'd17);
    d.push_back(8'd255);
    for (int i = 4; i < IN_DIM; i++) d.push_back(8'($urandom));
    send_frame(d, IN_DIM - 1);

    // Random mix of short, exact and overlong frames
    for (int f = 0; f < 8; f++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      last_at = $urandom_range(0, IN_DIM - 2);
      else if (kind == 1) last_at = IN_DIM - 1;
      else                last_at = $urandom_range(IN_DIM, IN_DIM + 16);
      d.delete();
      for (int i = 0; i <= last_at; i++) d.push_back(8'($urandom));
      next_wait = $urandom_range(0, 6);
      send_frame(d, last_at);
    end

    g = 0;
    while ((sb.size() != 0 || mon_busy) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("core_idle", mon_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
